// File: rtl/life_io_pkg.sv
// Shared types and helpers for the Game of Life board I/O adapter.
package life_io_pkg;

    typedef enum logic [1:0] {
        PAL_FULL = 2'd0,
        PAL_HALF = 2'd1,
        PAL_MONO = 2'd2,
        PAL_INV  = 2'd3
    } palette_mode_t;

    // Widest colour channel the expansion helper can produce.
    localparam int MAX_CH_W = 16;

    // Segment pattern {a,b,c,d,e,f,g}, active-high; non-decimal codes are blank.
    function automatic logic [6:0] seg7(input logic [3:0] bcd);
        logic [6:0] pat;
        case (bcd)
            4'd0:    pat = 7'b1111110;
            4'd1:    pat = 7'b0110000;
            4'd2:    pat = 7'b1101101;
            4'd3:    pat = 7'b1111001;
            4'd4:    pat = 7'b0110011;
            4'd5:    pat = 7'b1011011;
            4'd6:    pat = 7'b1011111;
            4'd7:    pat = 7'b1110000;
            4'd8:    pat = 7'b1111111;
            4'd9:    pat = 7'b1111011;
            default: pat = 7'b0000000;
        endcase
        return pat;
    endfunction

    // Expand one core colour bit into a channel of 'width' bits (low bits of the result).
    // any_on/is_green serve the mono mode, where only green lights for any lit pixel.
    function automatic logic [MAX_CH_W-1:0] expand_colour(
        input logic          c,
        input logic          any_on,
        input logic          is_green,
        input palette_mode_t mode,
        input int unsigned   width
    );
        logic [MAX_CH_W-1:0] full;
        logic [MAX_CH_W-1:0] result;
        full   = MAX_CH_W'((33'd1 << width) - 33'd1);
        result = '0;
        case (mode)
            PAL_FULL: result = c ? full : '0;
            PAL_HALF: result = c ? (full >> 1) : '0;
            PAL_MONO: result = (is_green && any_on) ? full : '0;
            PAL_INV:  result = c ? '0 : full;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/life_board_io_if.sv
// Video path between the game core and the VGA pins.
// Timing: *_in are sampled every clock; hsync/vsync/red/green/blue carry the
// same pixel one clock later. There is no back-pressure: every cycle is a pixel.
interface life_board_io_if #(
    parameter int w_vgar = 4,
    parameter int w_vgag = 4,
    parameter int w_vgab = 4
);
    logic              hsync_in;
    logic              vsync_in;
    logic [2:0]        rgb_in;
    logic              hsync;
    logic              vsync;
    logic [w_vgar-1:0] red;
    logic [w_vgag-1:0] green;
    logic [w_vgab-1:0] blue;

    // Core side: drives pixels, observes the pin-side outputs.
    modport master (
        output hsync_in, vsync_in, rgb_in,
        input  hsync, vsync, red, green, blue
    );

    // Adapter side: consumes pixels, drives the VGA pins.
    modport slave (
        input  hsync_in, vsync_in, rgb_in,
        output hsync, vsync, red, green, blue
    );
endinterface

// File: rtl/life_key_debounce.sv
// One-key debouncer: 2-flop synchronizer, stability counter, registered press pulse.
module life_key_debounce #(
    parameter int db_cnt_width = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic key_i,
    output logic level_o,
    output logic press_o
);
    logic                    sync1_q, sync2_q;
    logic [db_cnt_width-1:0] cnt_q, cnt_d;
    logic                    level_q, level_d;
    logic                    level_dly_q;
    logic                    press_q;

    // Count while the synchronized key disagrees with the accepted level; accept at all-ones.
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        if (sync2_q == level_q) begin
            cnt_d = '0;
        end else if (&cnt_q) begin
            level_d = sync2_q;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + db_cnt_width'(1);
        end
    end

    // Synchronizer, counter, level and press pulse registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            cnt_q       <= '0;
            level_q     <= 1'b0;
            level_dly_q <= 1'b0;
            press_q     <= 1'b0;
        end else begin
            sync1_q     <= key_i;
            sync2_q     <= sync1_q;
            cnt_q       <= cnt_d;
            level_q     <= level_d;
            level_dly_q <= level_q;
            press_q     <= level_q & ~level_dly_q;
        end
    end

    assign level_o = level_q;
    assign press_o = press_q;
endmodule

// File: rtl/life_board_io.sv
// Board-side adapter: key debounce, palette-expanded VGA, BCD generation
// counter shown on a multiplexed seven-segment display and the LEDs.
module life_board_io
    import life_io_pkg::*;
#(
    parameter int clk_mhz        = 50,
    parameter int w_key          = 4,
    parameter int w_sw           = 8,
    parameter int w_led          = 8,
    parameter int w_digit        = 8,
    parameter int w_vgar         = 4,
    parameter int w_vgag         = 4,
    parameter int w_vgab         = 4,
    parameter int db_cnt_width   = 16,
    parameter int scan_cnt_width = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [w_key-1:0]   key,
    input  logic [w_sw-1:0]    sw,
    output logic [w_key-1:0]   key_level,
    output logic [w_key-1:0]   key_press,
    input  logic               gen_tick,
    input  logic               gen_clear,
    life_board_io_if.slave     vga,
    output logic [7:0]         abcdefgh,
    output logic [w_digit-1:0] digit,
    output logic [w_led-1:0]   led
);
    localparam int BCD_W = 4 * w_digit;
    localparam int IDX_W = (w_digit > 1) ? $clog2(w_digit) : 1;
    localparam int unused_clk_mhz = clk_mhz;

    // Only sw[2:1] select the palette; the remaining switches are spare.
    logic unused_sw;
    assign unused_sw = ^sw;

    // ---------------- keys ----------------
    for (genvar i = 0; i < w_key; i++) begin : g_key
        life_key_debounce #(.db_cnt_width(db_cnt_width)) u_db (
            .clk     (clk),
            .rst     (rst),
            .key_i   (key[i]),
            .level_o (key_level[i]),
            .press_o (key_press[i])
        );
    end

    // ---------------- colour path ----------------
    palette_mode_t       mode;
    logic                any_on;
    logic [MAX_CH_W-1:0] red_x, green_x, blue_x;
    logic                hsync_q, vsync_q;
    logic [w_vgar-1:0]   red_q;
    logic [w_vgag-1:0]   green_q;
    logic [w_vgab-1:0]   blue_q;

    // Palette expansion of the current pixel.
    always_comb begin
        mode    = palette_mode_t'(sw[2:1]);
        any_on  = |vga.rgb_in;
        red_x   = expand_colour(vga.rgb_in[2], any_on, 1'b0, mode, w_vgar);
        green_x = expand_colour(vga.rgb_in[1], any_on, 1'b1, mode, w_vgag);
        blue_x  = expand_colour(vga.rgb_in[0], any_on, 1'b0, mode, w_vgab);
    end

    // One pixel of delay for colours and syncs alike, so they stay aligned.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hsync_q <= 1'b0;
            vsync_q <= 1'b0;
            red_q   <= '0;
            green_q <= '0;
            blue_q  <= '0;
        end else begin
            hsync_q <= vga.hsync_in;
            vsync_q <= vga.vsync_in;
            red_q   <= red_x[w_vgar-1:0];
            green_q <= green_x[w_vgag-1:0];
            blue_q  <= blue_x[w_vgab-1:0];
        end
    end

    assign vga.hsync = hsync_q;
    assign vga.vsync = vsync_q;
    assign vga.red   = red_q;
    assign vga.green = green_q;
    assign vga.blue  = blue_q;

    // ---------------- generation counter ----------------
    logic [BCD_W-1:0] bcd_q, bcd_d;
    logic             carry;

    // Ripple decimal increment; clear overrides a simultaneous tick.
    always_comb begin
        bcd_d = bcd_q;
        carry = gen_tick;
        for (int i = 0; i < w_digit; i++) begin
            if (carry) begin
                if (bcd_q[4*i +: 4] == 4'd9) begin
                    bcd_d[4*i +: 4] = 4'd0;
                end else begin
                    bcd_d[4*i +: 4] = bcd_q[4*i +: 4] + 4'd1;
                    carry           = 1'b0;
                end
            end
        end
        if (gen_clear) begin
            bcd_d = '0;
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) bcd_q <= '0;
        else     bcd_q <= bcd_d;
    end

    // LEDs show the low counter bits, zero-extended when the counter is narrower.
    logic [BCD_W+w_led-1:0] led_wide_unused;
    assign led_wide_unused = {{w_led{1'b0}}, bcd_q};
    assign led             = led_wide_unused[w_led-1:0];

    // ---------------- display scan ----------------
    logic [scan_cnt_width-1:0] scan_q;
    logic [IDX_W-1:0]          idx_q;
    logic                      strobe;
    logic [3:0]                cur_bcd;
    logic [w_digit-1:0]        digit_d;
    logic [w_digit-1:0]        digit_q;
    logic [7:0]                seg_q;

    // Select the BCD digit and one-hot enable for the current scan index.
    always_comb begin
        strobe  = &scan_q;
        cur_bcd = 4'd0;
        digit_d = '0;
        for (int i = 0; i < w_digit; i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_bcd    = bcd_q[4*i +: 4];
                digit_d[i] = 1'b1;
            end
        end
    end

    // Free-running scan counter; digit enable and segments update together on wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_q  <= '0;
            idx_q   <= '0;
            digit_q <= '0;
            seg_q   <= 8'h00;
        end else begin
            scan_q <= scan_q + scan_cnt_width'(1);
            if (strobe) begin
                digit_q <= digit_d;
                seg_q   <= {seg7(cur_bcd), 1'b0};
                idx_q   <= (idx_q == IDX_W'(w_digit - 1)) ? '0 : idx_q + IDX_W'(1);
            end
        end
    end

    assign digit    = digit_q;
    assign abcdefgh = seg_q;
endmodule

// File: tb/tb_life_board_io.sv
module tb_life_board_io;
  localparam int W_KEY    = 4;
  localparam int W_SW     = 8;
  localparam int W_LED    = 8;
  localparam int W_DIGIT  = 2;
  localparam int W_CH     = 4;
  localparam int DB       = 3;
  localparam int SCAN     = 2;
  localparam int DB_LEN   = 1 << DB;
  localparam int SCAN_LEN = 1 << SCAN;
  localparam int HIST     = DB_LEN + 4;

  // ---------------- clock / reset / DUT ----------------
  logic               clk;
  logic               rst;
  logic [W_KEY-1:0]   key;
  logic [W_SW-1:0]    sw;
  logic [W_KEY-1:0]   key_level;
  logic [W_KEY-1:0]   key_press;
  logic               gen_tick;
  logic               gen_clear;
  logic [7:0]         abcdefgh;
  logic [W_DIGIT-1:0] digit;
  logic [W_LED-1:0]   led;

  life_board_io_if #(.w_vgar(W_CH), .w_vgag(W_CH), .w_vgab(W_CH)) vga ();

  life_board_io #(
    .clk_mhz(50), .w_key(W_KEY), .w_sw(W_SW), .w_led(W_LED), .w_digit(W_DIGIT),
    .w_vgar(W_CH), .w_vgag(W_CH), .w_vgab(W_CH),
    .db_cnt_width(DB), .scan_cnt_width(SCAN)
  ) dut (
    .clk(clk), .rst(rst), .key(key), .sw(sw),
    .key_level(key_level), .key_press(key_press),
    .gen_tick(gen_tick), .gen_clear(gen_clear),
    .vga(vga),
    .abcdefgh(abcdefgh), .digit(digit), .led(led)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- scoreboard ----------------
  int total;
  int bad;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Segments {a..g,dp} for decimal digits.
  logic [7:0] seg_tab [10] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66,
                              8'hB6, 8'hBE, 8'hE0, 8'hFE, 8'hF6};

  logic [W_KEY-1:0]   kq [$];       // key samples, one per clock edge, newest last
  logic [W_KEY-1:0]   m_level;
  logic [W_KEY-1:0]   m_level_d1;
  logic [W_KEY-1:0]   m_press;
  logic               m_hs, m_vs;
  logic [W_CH-1:0]    m_r, m_g, m_b;
  int                 m_gen;        // generation count as a plain integer
  int                 m_n;          // clock edges since reset release
  logic [W_DIGIT-1:0] m_digit;
  logic [7:0]         m_seg;

  function automatic logic [W_LED-1:0] model_led();
    return W_LED'(((m_gen / 10) % 10) * 16 + (m_gen % 10));
  endfunction

  task automatic model_reset();
    kq.delete();
    for (int i = 0; i < HIST; i++) kq.push_back('0);
    m_level = '0; m_level_d1 = '0; m_press = '0;
    m_hs = 1'b0; m_vs = 1'b0; m_r = '0; m_g = '0; m_b = '0;
    m_gen = 0; m_n = 0; m_digit = '0; m_seg = 8'h00;
  endtask

  // One clock edge: inputs are the values presented before the edge.
  task automatic model_step();
    logic [W_KEY-1:0] nlevel;
    logic [W_CH-1:0]  on;
    bit               all_diff;
    int               k;
    // Press: level rose between the two previous edges.
    m_press    = m_level & ~m_level_d1;
    m_level_d1 = m_level;
    // A key is accepted once the synchronized value (2 edges late) has
    // disagreed with the accepted level for DB_LEN consecutive edges.
    kq.push_back(key);
    if (kq.size() > HIST) void'(kq.pop_front());
    nlevel = m_level;
    for (int i = 0; i < W_KEY; i++) begin
      all_diff = 1'b1;
      for (int j = 2; j < 2 + DB_LEN; j++)
        if (kq[kq.size() - 1 - j][i] == m_level[i]) all_diff = 1'b0;
      if (all_diff) nlevel[i] = ~m_level[i];
    end
    m_level = nlevel;
    // Colour path.
    on   = '1;
    m_hs = vga.hsync_in;
    m_vs = vga.vsync_in;
    case (sw[2:1])
      2'd0: begin
        m_r = vga.rgb_in[2] ? on : '0; m_g = vga.rgb_in[1] ? on : '0; m_b = vga.rgb_in[0] ? on : '0;
      end
      2'd1: begin
        m_r = vga.rgb_in[2] ? (on >> 1) : '0; m_g = vga.rgb_in[1] ? (on >> 1) : '0;
        m_b = vga.rgb_in[0] ? (on >> 1) : '0;
      end
      2'd2: begin
        m_r = '0; m_b = '0; m_g = (vga.rgb_in != 3'b000) ? on : '0;
      end
      default: begin
        m_r = vga.rgb_in[2] ? '0 : on; m_g = vga.rgb_in[1] ? '0 : on; m_b = vga.rgb_in[0] ? '0 : on;
      end
    endcase
    // Display strobe every SCAN_LEN edges, showing the count before this edge.
    m_n++;
    if (m_n % SCAN_LEN == 0) begin
      k       = (m_n / SCAN_LEN - 1) % W_DIGIT;
      m_digit = W_DIGIT'(1 << k);
      m_seg   = seg_tab[(k == 0) ? (m_gen % 10) : ((m_gen / 10) % 10)];
    end
    // Generation count.
    if (gen_clear)     m_gen = 0;
    else if (gen_tick) m_gen = (m_gen + 1) % 100;
  endtask

  task automatic check_all();
    check("key_level", 32'(key_level), 32'(m_level));
    check("key_press", 32'(key_press), 32'(m_press));
    check("hsync", 32'(vga.hsync), 32'(m_hs));
    check("vsync", 32'(vga.vsync), 32'(m_vs));
    check("red", 32'(vga.red), 32'(m_r));
    check("green", 32'(vga.green), 32'(m_g));
    check("blue", 32'(vga.blue), 32'(m_b));
    check("abcdefgh", 32'(abcdefgh), 32'(m_seg));
    check("digit", 32'(digit), 32'(m_digit));
    check("led", 32'(led), 32'(model_led()));
  endtask

  // ---------------- driver ----------------
  task automatic cyc();
    @(posedge clk);
    if (!rst) model_step();
    @(negedge clk);
    check_all();
  endtask

  logic [W_CH-1:0]    exp_r [4] = '{4'hF, 4'h7, 4'h0, 4'h0};
  logic [W_CH-1:0]    exp_g [4] = '{4'h0, 4'h0, 4'hF, 4'hF};
  logic [W_CH-1:0]    exp_b [4] = '{4'hF, 4'h7, 4'h0, 4'h0};
  int                 press0_seen;
  int                 changes;
  int                 found;
  logic [W_DIGIT-1:0] prev_digit;

  initial begin
    total = 0; bad = 0;
    rst = 1'b0; key = '0; sw = '0; gen_tick = 1'b0; gen_clear = 1'b0;
    vga.hsync_in = 1'b0; vga.vsync_in = 1'b0; vga.rgb_in = 3'b000;
    model_reset();
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    check_all();
    rst = 1'b0;

    // Clean key[1] edge after 10 edges: level 10 edges later, press the edge after.
    repeat (10) cyc();
    key[1] = 1'b1;
    repeat (9) cyc();
    check("lvl1_before", 32'(key_level[1]), 32'd0);
    cyc();
    check("lvl1_rise", 32'(key_level[1]), 32'd1);
    check("press1_not_yet", 32'(key_press[1]), 32'd0);
    cyc();
    check("press1_pulse", 32'(key_press[1]), 32'd1);
    cyc();
    check("press1_end", 32'(key_press[1]), 32'd0);

    // Bouncing key[0]: never stable long enough.
    press0_seen = 0;
    for (int c = 0; c < 40; c++) begin
      if (c % 4 == 0) key[0] = ~key[0];
      cyc();
      if (key_press[0]) press0_seen++;
    end
    key[0] = 1'b0;
    repeat (12) begin
      cyc();
      if (key_press[0]) press0_seen++;
    end
    check("bounce_level", 32'(key_level[0]), 32'd0);
    check("bounce_press", 32'(press0_seen), 32'd0);

    // Palette modes with rgb=101, syncs travelling alongside.
    for (int m = 0; m < 4; m++) begin
      sw = W_SW'(m << 1);
      vga.rgb_in = 3'b101; vga.hsync_in = 1'b1; vga.vsync_in = 1'b0;
      cyc();
      check("pal_red", 32'(vga.red), 32'(exp_r[m]));
      check("pal_green", 32'(vga.green), 32'(exp_g[m]));
      check("pal_blue", 32'(vga.blue), 32'(exp_b[m]));
      check("pal_hsync", 32'(vga.hsync), 32'd1);
      vga.rgb_in = 3'b000; vga.hsync_in = 1'b0; vga.vsync_in = 1'b1;
      cyc();
      check("pal_vsync", 32'(vga.vsync), 32'd1);
    end

    // Generation counter: 99, wrap, clear priority.
    key[3] = 1'b1;
    gen_clear = 1'b1; cyc(); gen_clear = 1'b0;
    gen_tick = 1'b1;
    repeat (99) cyc();
    gen_tick = 1'b0;
    check("led_99", 32'(led), 32'h99);
    gen_tick = 1'b1; cyc(); gen_tick = 1'b0;
    check("led_wrap", 32'(led), 32'h00);
    gen_tick = 1'b1;
    repeat (5) cyc();
    gen_clear = 1'b1; cyc();
    gen_tick = 1'b0; gen_clear = 1'b0;
    check("led_clear_prio", 32'(led), 32'h00);

    // Count 42 and watch the scan alternate.
    gen_tick = 1'b1;
    repeat (42) cyc();
    gen_tick = 1'b0;
    check("led_42", 32'(led), 32'h42);
    repeat (SCAN_LEN) cyc();
    changes = 0;
    prev_digit = digit;
    repeat (4 * SCAN_LEN) begin
      cyc();
      if (digit !== prev_digit) changes++;
      prev_digit = digit;
      if (digit === 2'b01) check("scan_ones", 32'(abcdefgh), 32'hDA);
      else                 check("scan_tens", 32'(abcdefgh), 32'h66);
    end
    check("scan_strobes", 32'(changes), 32'd4);

    // Reset mid-operation while keys are held.
    key[2] = 1'b1;
    sw = 8'h00; vga.rgb_in = 3'b111; vga.hsync_in = 1'b1; vga.vsync_in = 1'b1;
    repeat (3) cyc();
    #2 rst = 1'b1;
    model_reset();
    #1;
    check("rst_level", 32'(key_level), 32'd0);
    check("rst_press", 32'(key_press), 32'd0);
    check("rst_red", 32'(vga.red), 32'd0);
    check("rst_hsync", 32'(vga.hsync), 32'd0);
    check("rst_seg", 32'(abcdefgh), 32'd0);
    check("rst_digit", 32'(digit), 32'd0);
    check("rst_led", 32'(led), 32'd0);
    repeat (2) cyc();
    rst = 1'b0;
    found = 0;
    for (int k = 1; k <= 30; k++) begin
      cyc();
      if (k == 1) check("rel_no_press", 32'(key_press), 32'd0);
      if (key_level[2] && found == 0) found = k;
    end
    check("rel_accept", 32'(found), 32'd10);

    // Randomized traffic against the model.
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < W_KEY; i++)
        if ($urandom_range(0, 11) == 0) key[i] = ~key[i];
      sw           = W_SW'($urandom);
      vga.rgb_in   = 3'($urandom);
      vga.hsync_in = 1'($urandom);
      vga.vsync_in = 1'($urandom);
      gen_tick     = 1'($urandom);
      gen_clear    = ($urandom_range(0, 29) == 0);
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
